aurora64b66b_link_ctrl: RTL and testbench
=========================================

# aurora64b66b_link_ctrl

Link supervisor and reset sequencer for the multi-channel Aurora 64b66b wrapper. It runs in the free-running `init_clk` domain, drives the wrapper's active-high common `reset`, and holds it for a fixed time. It then waits for every channel to report `channel_up`, and on timeout, channel drop, hard error or excessive soft-error rate it re-runs the reset sequence and counts the retry. It gives system logic one registered `link_ready` flag plus diagnostics.

## Interface
- `CH_CNT`, 3, number of Aurora channels supervised
- `RST_CYCLES`, 1024, cycles `link_reset` is held high per sequence (≥2)
- `UP_TIMEOUT`, 1048576, cycles allowed in WAIT_UP before a retry (≥2)
- `SOFT_ERR_WIN`, 1024, soft-error observation window in cycles (≥2)
- `SOFT_ERR_MAX`, 15, soft-error cycles per window that trigger a fault (≥1)
- `RETRY_W`, 8, width of the retry counter

- `init_clk`  in  1  free-running clock; sole clock of the block
- `reset_n`  in  1  asynchronous, active-low reset
- `restart`  in  1  single-cycle request to re-run the reset sequence
- `channel_up`  in  CH_CNT  per-channel link status, asynchronous to `init_clk`
- `hard_err`  in  CH_CNT  per-channel hard error, asynchronous
- `soft_err`  in  CH_CNT  per-channel soft error, asynchronous
- `link_reset`  out  1  common reset to the Aurora wrapper, active high
- `link_ready`  out  1  all channels up and no fault
- `state`  out  2  0 RESET_ASSERT, 1 WAIT_UP, 2 LINKED
- `retry_cnt`  out  RETRY_W  number of fault-triggered retries, saturating
- `fault_ch`  out  CH_CNT  channels implicated in the last fault

## Operation
- `channel_up`, `hard_err` and `soft_err` each pass through a 2-FF synchronizer. Below, `up_s`, `herr_s` and `serr_s` are the synchronized values.
- Reset values: state RESET_ASSERT, `link_reset` 1, `link_ready` 0, `retry_cnt` 0, `fault_ch` 0, all timers 0.
- **RESET_ASSERT**
  - `link_reset` is 1 and the timer counts from 0.
  - When the timer reaches RST_CYCLES-1, the block moves to WAIT_UP and the timer clears.
- **WAIT_UP**
  - `link_reset` is 0.
  - If `&up_s` is set, the block moves to LINKED.
  - Otherwise, when the timer reaches UP_TIMEOUT-1, it raises a timeout fault.
- **LINKED**
  - `link_ready` is 1.
  - If `~&up_s` or `|herr_s` is set, the block raises a fault.
- Fault handling:
  - Next state is RESET_ASSERT.
  - `retry_cnt` increments, saturating at all-ones.
  - `fault_ch` is loaded with `~up_s | herr_s`. A timeout fault loads `~up_s`.
- `restart` is honoured in any state, including RESET_ASSERT:
  - The block moves to RESET_ASSERT and the timer clears.
  - `retry_cnt` and `fault_ch` are left unchanged.
  - `restart` has priority over any fault or timeout in the same cycle.
- When a fault and `&up_s` coincide in WAIT_UP on the timeout cycle, `&up_s` wins and the block moves to LINKED.
- A `reset_n` assertion in any state returns everything to the reset values immediately.

## Timing
- Outputs are registered. `link_reset`, `link_ready` and `state` change in the cycle after the deciding edge.
- Input-to-decision latency is 2 cycles (synchronizer). A `channel_up` drop lowers `link_ready` 3 cycles later.
- After `reset_n` rises, `link_reset` stays 1 for exactly RST_CYCLES cycles.
- A WAIT_UP timeout occurs UP_TIMEOUT cycles after entry.
- Timers are `$clog2` of their maximum wide and never wrap. Each clears on every state entry.

## Configuration
- `AURORA_LINK_CTRL_SOFT_ERR_EN` defined:
  - In LINKED, a window timer runs from 0 to SOFT_ERR_WIN-1 and a counter counts cycles with `|serr_s`.
  - When the counter reaches SOFT_ERR_MAX within one window, the block raises a fault and `fault_ch` is loaded with the channels whose `serr_s` bit is set in that cycle.
  - At window end the counter clears. If `|serr_s` is set in the wrap cycle, it counts as 1 in the new window.
  - Window timer and counter both clear on entry to LINKED.
- Not defined: `soft_err` is ignored and its synchronizer, window timer and counter are not built.

## Test plan
- Release `reset_n`; hold `channel_up`=3'b111 → `link_reset`=1 for 1024 cycles, LINKED and `link_ready`=1 within 3 cycles of WAIT_UP entry, `retry_cnt`=0.
- `channel_up`=3'b101 permanently, UP_TIMEOUT=64 → timeout retries repeat, `fault_ch`=3'b010, `retry_cnt`=1,2,3…; with RETRY_W=2 it saturates at 3.
- In LINKED, pulse `hard_err[2]` for 1 cycle → `link_ready` 0 after 3 cycles, `link_reset`=1 for RST_CYCLES, `fault_ch`=3'b100.
- `restart` on the same cycle as a synchronized `channel_up` drop in LINKED → RESET_ASSERT, `retry_cnt` and `fault_ch` unchanged.
- With the macro defined, SOFT_ERR_WIN=32, SOFT_ERR_MAX=4: 3 soft-error cycles per window never faults; 4 within one window faults with `fault_ch` equal to the erring channel.
- Assert `reset_n` mid-WAIT_UP → all outputs take reset values immediately, asynchronously.

Source files
------------

// File: rtl/aurora64b66b_link_ctrl.sv
// Aurora 64b66b link supervisor: reset sequencing, channel-up watchdog, retry count.
// Optional soft-error rate fault when AURORA_LINK_CTRL_SOFT_ERR_EN is defined.
module aurora64b66b_link_ctrl #(
    parameter int CH_CNT       = 3,
    parameter int RST_CYCLES   = 1024,
    parameter int UP_TIMEOUT   = 1048576,
    parameter int SOFT_ERR_WIN = 1024,
    parameter int SOFT_ERR_MAX = 15,
    parameter int RETRY_W      = 8
) (
    input  logic               init_clk,
    input  logic               reset_n,
    input  logic               restart,
    input  logic [CH_CNT-1:0]  channel_up,
    input  logic [CH_CNT-1:0]  hard_err,
    input  logic [CH_CNT-1:0]  soft_err,
    output logic               link_reset,
    output logic               link_ready,
    output logic [1:0]         state,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [CH_CNT-1:0]  fault_ch
);

    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_WAIT   = 2'd1,
        S_LINKED = 2'd2
    } state_t;

    localparam int TMAX = (RST_CYCLES > UP_TIMEOUT) ? RST_CYCLES : UP_TIMEOUT;
    localparam int TW   = $clog2(TMAX);
    localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] UP_LAST  = TW'(UP_TIMEOUT - 1);

    state_t              r_state;
    state_t              w_nxt;
    logic [TW-1:0]       r_tmr;
    logic [TW-1:0]       w_tmr_nxt;
    logic                r_link_reset;
    logic                r_link_ready;
    logic [RETRY_W-1:0]  r_retry;
    logic [CH_CNT-1:0]   r_fault_ch;
    logic [CH_CNT-1:0]   w_fault_ch_nxt;
    logic                w_fault;

    logic [CH_CNT-1:0]   r_up_m;
    logic [CH_CNT-1:0]   r_up_s;
    logic [CH_CNT-1:0]   r_herr_m;
    logic [CH_CNT-1:0]   r_herr_s;

    logic                w_all_up;
    logic                w_link_flt;
    logic [CH_CNT-1:0]   w_link_ch;
    logic                w_soft_flt;
    logic [CH_CNT-1:0]   w_soft_ch;

    // Status inputs come from the wrapper's user clock domain
    always_ff @(posedge init_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_up_m   <= '0;
            r_up_s   <= '0;
            r_herr_m <= '0;
            r_herr_s <= '0;
        end else begin
            r_up_m   <= channel_up;
            r_up_s   <= r_up_m;
            r_herr_m <= hard_err;
            r_herr_s <= r_herr_m;
        end
    end

    assign w_all_up   = &r_up_s;
    assign w_link_ch  = ~r_up_s | r_herr_s;
    assign w_link_flt = ~w_all_up | (|r_herr_s);

`ifdef AURORA_LINK_CTRL_SOFT_ERR_EN
    localparam int WW = $clog2(SOFT_ERR_WIN);
    localparam int CW = $clog2(SOFT_ERR_MAX + 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(SOFT_ERR_WIN - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SOFT_ERR_MAX);

    logic [CH_CNT-1:0] r_serr_m;
    logic [CH_CNT-1:0] r_serr_s;
    logic [WW-1:0]     r_win;
    logic [CW-1:0]     r_scnt;
    logic              w_win_end;
    logic              w_serr_any;
    logic [CW-1:0]     w_scnt_nxt;

    assign w_win_end  = (r_win == WIN_LAST);
    assign w_serr_any = |r_serr_s;
    // An error in the wrap cycle is the first count of the new window
    assign w_scnt_nxt = (w_win_end ? '0 : r_scnt) + CW'(w_serr_any);
    assign w_soft_flt = (r_state == S_LINKED) && w_serr_any
                        && (w_scnt_nxt == CNT_MAX);
    assign w_soft_ch  = r_serr_s;

    always_ff @(posedge init_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_serr_m <= '0;
            r_serr_s <= '0;
            r_win    <= '0;
            r_scnt   <= '0;
        end else begin
            r_serr_m <= soft_err;
            r_serr_s <= r_serr_m;
            if (r_state == S_LINKED) begin
                r_win  <= w_win_end ? '0 : r_win + WW'(1);
                r_scnt <= w_scnt_nxt;
            end else begin
                r_win  <= '0;
                r_scnt <= '0;
            end
        end
    end
`else
    logic w_unused_soft;

    assign w_unused_soft = ^{soft_err,
                             1'(SOFT_ERR_WIN % 2),
                             1'(SOFT_ERR_MAX % 2)};
    assign w_soft_flt    = 1'b0;
    assign w_soft_ch     = '0;
`endif

    always_comb begin
        w_nxt          = r_state;
        w_tmr_nxt      = r_tmr;
        w_fault        = 1'b0;
        w_fault_ch_nxt = r_fault_ch;
        unique case (r_state)
            S_RESET: begin
                if (r_tmr == RST_LAST) begin
                    w_nxt     = S_WAIT;
                    w_tmr_nxt = '0;
                end else begin
                    w_tmr_nxt = r_tmr + TW'(1);
                end
            end
            S_WAIT: begin
                if (w_all_up) begin
                    w_nxt     = S_LINKED;
                    w_tmr_nxt = '0;
                end else if (r_tmr == UP_LAST) begin
                    w_nxt          = S_RESET;
                    w_tmr_nxt      = '0;
                    w_fault        = 1'b1;
                    w_fault_ch_nxt = ~r_up_s;
                end else begin
                    w_tmr_nxt = r_tmr + TW'(1);
                end
            end
            S_LINKED: begin
                w_tmr_nxt = '0;
                if (w_link_flt || w_soft_flt) begin
                    w_nxt          = S_RESET;
                    w_fault        = 1'b1;
                    w_fault_ch_nxt = (w_link_flt ? w_link_ch : '0)
                                   | (w_soft_flt ? w_soft_ch : '0);
                end
            end
            default: begin
                w_nxt     = S_RESET;
                w_tmr_nxt = '0;
            end
        endcase
        // Operator restart overrides any fault decided this cycle
        if (restart) begin
            w_nxt          = S_RESET;
            w_tmr_nxt      = '0;
            w_fault        = 1'b0;
            w_fault_ch_nxt = r_fault_ch;
        end
    end

    always_ff @(posedge init_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_RESET;
            r_tmr        <= '0;
            r_link_reset <= 1'b1;
            r_link_ready <= 1'b0;
            r_retry      <= '0;
            r_fault_ch   <= '0;
        end else begin
            r_state      <= w_nxt;
            r_tmr        <= w_tmr_nxt;
            r_link_reset <= (w_nxt == S_RESET);
            r_link_ready <= (w_nxt == S_LINKED);
            r_fault_ch   <= w_fault_ch_nxt;
            if (w_fault && !(&r_retry)) begin
                r_retry <= r_retry + RETRY_W'(1);
            end
        end
    end

    assign link_reset = r_link_reset;
    assign link_ready = r_link_ready;
    assign state      = r_state;
    assign retry_cnt  = r_retry;
    assign fault_ch   = r_fault_ch;

endmodule

// File: tb/tb_aurora64b66b_link_ctrl.sv
// Directed bench for aurora64b66b_link_ctrl (short UP_TIMEOUT, 2-bit retry counter).
// Soft-error steps run only when AURORA_LINK_CTRL_SOFT_ERR_EN is defined.
module tb_aurora64b66b_link_ctrl;

    logic       clk;
    logic       reset_n;
    logic       restart;
    logic [2:0] channel_up;
    logic [2:0] hard_err;
    logic [2:0] soft_err;
    logic       link_reset;
    logic       link_ready;
    logic [1:0] state;
    logic [1:0] retry_cnt;
    logic [2:0] fault_ch;

    int checks = 0;
    int errors = 0;

    aurora64b66b_link_ctrl #(
        .CH_CNT      (3),
        .RST_CYCLES  (1024),
        .UP_TIMEOUT  (64),
        .SOFT_ERR_WIN(32),
        .SOFT_ERR_MAX(4),
        .RETRY_W     (2)
    ) dut (
        .init_clk  (clk),
        .reset_n   (reset_n),
        .restart   (restart),
        .channel_up(channel_up),
        .hard_err  (hard_err),
        .soft_err  (soft_err),
        .link_reset(link_reset),
        .link_ready(link_ready),
        .state     (state),
        .retry_cnt (retry_cnt),
        .fault_ch  (fault_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int exp_retry;
        reset_n    = 1'b0;
        restart    = 1'b0;
        channel_up = 3'b111;
        hard_err   = 3'b000;
        soft_err   = 3'b000;
        repeat (3) @(negedge clk);
        chk("rst_link_reset", 32'(link_reset), 1);
        chk("rst_link_ready", 32'(link_ready), 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_retry", 32'(retry_cnt), 0);
        chk("rst_fault_ch", 32'(fault_ch), 0);

        // Reset release: link_reset held for RST_CYCLES, then quick link-up
        reset_n = 1'b1;
        n = 0;
        while (link_reset && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("init_rst_len", 32'(n), 1024);
        chk("init_wait_state", 32'(state), 1);
        n = 0;
        while (!link_ready && n < 3) begin
            @(negedge clk);
            n++;
        end
        chk("init_ready", 32'(link_ready), 1);
        chk("init_linked", 32'(state), 2);
        chk("init_retry", 32'(retry_cnt), 0);

        // One-cycle hard error on channel 2
        hard_err = 3'b100;
        @(negedge clk);
        hard_err = 3'b000;
        @(negedge clk);
        chk("herr_ready_2cyc", 32'(link_ready), 1);
        @(negedge clk);
        chk("herr_ready_3cyc", 32'(link_ready), 0);
        chk("herr_state", 32'(state), 0);
        chk("herr_link_reset", 32'(link_reset), 1);
        chk("herr_fault_ch", 32'(fault_ch), 32'b100);
        chk("herr_retry", 32'(retry_cnt), 1);
        n = 0;
        while (link_reset && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("herr_rst_len", 32'(n), 1024);
        n = 0;
        while (!link_ready && n < 3) begin
            @(negedge clk);
            n++;
        end
        chk("herr_relink", 32'(link_ready), 1);

        // Restart coincides with synchronized drop of channel 0
        channel_up = 3'b110;
        @(negedge clk);
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("rs_state", 32'(state), 0);
        chk("rs_ready", 32'(link_ready), 0);
        chk("rs_retry", 32'(retry_cnt), 1);
        chk("rs_fault_ch", 32'(fault_ch), 32'b100);

        // Channel 1 never comes up: repeated timeouts, retry saturates at 3
        channel_up = 3'b101;
        for (int k = 0; k < 4; k++) begin
            exp_retry = (k + 2 > 3) ? 3 : k + 2;
            n = 0;
            while (link_reset && n < 1100) begin
                @(negedge clk);
                n++;
            end
            chk("to_wait_state", 32'(state), 1);
            n = 0;
            while (!link_reset && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("to_wait_len", 32'(n), 64);
            chk("to_fault_ch", 32'(fault_ch), 32'b010);
            chk("to_retry", 32'(retry_cnt), 32'(exp_retry));
        end

`ifdef AURORA_LINK_CTRL_SOFT_ERR_EN
        channel_up = 3'b111;
        n = 0;
        while (!link_ready && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk("se_linked", 32'(link_ready), 1);
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 32; i++) begin
                soft_err = (i < 3) ? 3'b010 : 3'b000;
                @(negedge clk);
            end
        end
        chk("se_3_no_fault", 32'(link_ready), 1);
        chk("se_3_state", 32'(state), 2);
        for (int i = 0; i < 32; i++) begin
            soft_err = (i < 4) ? 3'b010 : 3'b000;
            @(negedge clk);
        end
        soft_err = 3'b000;
        chk("se_4_ready", 32'(link_ready), 0);
        chk("se_4_state", 32'(state), 0);
        chk("se_4_fault_ch", 32'(fault_ch), 32'b010);
        chk("se_4_retry", 32'(retry_cnt), 3);
`endif

        // Asynchronous reset in the middle of WAIT_UP
        channel_up = 3'b101;
        n = 0;
        while (link_reset && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk("ar_wait_state", 32'(state), 1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_link_reset", 32'(link_reset), 1);
        chk("ar_link_ready", 32'(link_ready), 0);
        chk("ar_state", 32'(state), 0);
        chk("ar_retry", 32'(retry_cnt), 0);
        chk("ar_fault_ch", 32'(fault_ch), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
